// File: rtl/bbox_scan.sv
// Raster-scans a synchronous-read image memory and reports the bounding box of
// pixels at or above THRESH; the box is held until the next completed scan.
module bbox_scan #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int PIX_W  = 8,
    parameter int THRESH = 128,
    parameter int ADDR_W = 16,
    parameter int X_W    = $clog2(WIDTH),
    parameter int Y_W    = $clog2(HEIGHT)
) (
    input  logic              CLOCK_50,
    input  logic [3:0]        KEY,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [X_W-1:0]    x_min,
    output logic [X_W-1:0]    x_max,
    output logic [Y_W-1:0]    y_min,
    output logic [Y_W-1:0]    y_max,
    output logic [1:0]        state_dbg
);

    // Control contract: start is sampled only in IDLE or DONE (busy=0); done
    // stays high with the box stable until the next accepted start.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [X_W-1:0]   X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST = Y_W'(HEIGHT - 1);
    localparam logic [PIX_W-1:0] THR    = PIX_W'(THRESH);

    state_t         state;
    logic           rst_n;
    logic [X_W-1:0] x_cnt, px;
    logic [Y_W-1:0] y_cnt, py;
    logic           pix_valid;
    logic           run_found, nxt_found, hit;
    logic [X_W-1:0] run_xmin, run_xmax, nxt_xmin, nxt_xmax;
    logic [Y_W-1:0] run_ymin, run_ymax, nxt_ymin, nxt_ymax;
    logic           unused_key;

    assign rst_n      = KEY[3];
    assign unused_key = ^KEY[2:0];
    assign state_dbg  = state;

    // Next running box including the pixel currently on rd_data, so the final
    // pixel can be folded in on the same edge that loads the outputs.
    always_comb begin
        hit       = pix_valid && (rd_data >= THR);
        nxt_found = run_found;
        nxt_xmin  = run_xmin;
        nxt_xmax  = run_xmax;
        nxt_ymin  = run_ymin;
        nxt_ymax  = run_ymax;
        if (hit) begin
            nxt_found = 1'b1;
            nxt_xmin  = (px < run_xmin) ? px : run_xmin;
            nxt_xmax  = (px > run_xmax) ? px : run_xmax;
            nxt_ymin  = (py < run_ymin) ? py : run_ymin;
            nxt_ymax  = (py > run_ymax) ? py : run_ymax;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rd_addr   <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            px        <= '0;
            py        <= '0;
            pix_valid <= 1'b0;
            run_found <= 1'b0;
            run_xmin  <= '0;
            run_xmax  <= '0;
            run_ymin  <= '0;
            run_ymax  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
        end else begin
            // Pixel for the address issued this cycle returns next cycle.
            pix_valid <= (state == S_SCAN);
            px        <= x_cnt;
            py        <= y_cnt;
            run_found <= nxt_found;
            run_xmin  <= nxt_xmin;
            run_xmax  <= nxt_xmax;
            run_ymin  <= nxt_ymin;
            run_ymax  <= nxt_ymax;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_SCAN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        rd_addr   <= '0;
                        x_cnt     <= '0;
                        y_cnt     <= '0;
                        run_found <= 1'b0;
                        run_xmin  <= X_LAST;
                        run_xmax  <= '0;
                        run_ymin  <= Y_LAST;
                        run_ymax  <= '0;
                    end
                end
                S_SCAN: begin
                    if (x_cnt == X_LAST && y_cnt == Y_LAST) begin
                        state <= S_DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + Y_W'(1);
                        end else begin
                            x_cnt <= x_cnt + X_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    found <= nxt_found;
                    x_min <= nxt_found ? nxt_xmin : '0;
                    x_max <= nxt_found ? nxt_xmax : '0;
                    y_min <= nxt_found ? nxt_ymin : '0;
                    y_max <= nxt_found ? nxt_ymax : '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_scan.sv
// Bench for bbox_scan on an 8x8 image: a behavioural memory, a reference box
// model feeding an expected-result queue, and cycle-exact timing checks.
module tb_bbox_scan;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic        CLOCK_50;
    logic [3:0]  KEY;
    logic        start;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy, done, found;
    logic [2:0]  x_min, x_max, y_min, y_max;
    logic [1:0]  state_dbg;

    logic [7:0]  mem [N];
    logic [12:0] exp_q [$];
    int          checks;
    int          errors;

    bbox_scan #(.WIDTH(W), .HEIGHT(H), .PIX_W(8), .THRESH(128), .ADDR_W(16)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .found    (found),
        .x_min    (x_min),
        .x_max    (x_max),
        .y_min    (y_min),
        .y_max    (y_max),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / memory ----------------
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) rd_data <= mem[rd_addr[5:0]];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] box_out();
        return {found, x_min, x_max, y_min, y_max};
    endfunction

    // Reference: {found, x_min, x_max, y_min, y_max}; all zero for empty image.
    function automatic logic [12:0] model_box();
        logic       f;
        logic [2:0] x0, x1, y0, y1;
        f = 1'b0; x0 = '0; x1 = '0; y0 = '0; y1 = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (mem[y * W + x] >= 8'd128) begin
                    if (!f) begin
                        x0 = 3'(x); x1 = 3'(x); y0 = 3'(y); y1 = 3'(y);
                        f = 1'b1;
                    end else begin
                        if (3'(x) < x0) x0 = 3'(x);
                        if (3'(x) > x1) x1 = 3'(x);
                        if (3'(y) < y0) y0 = 3'(y);
                        if (3'(y) > y1) y1 = 3'(y);
                    end
                end
            end
        end
        return {f, x0, x1, y0, y1};
    endfunction

    // ---------------- image drivers ----------------
    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    task automatic set_px(input int x, input int y, input logic [7:0] v);
        mem[y * W + x] = v;
    endtask

    task automatic load_square();
        fill(8'h00);
        for (int y = 2; y <= 5; y++)
            for (int x = 3; x <= 6; x++) set_px(x, y, 8'hFF);
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++)
            mem[i] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(128, 255))
                                                 : 8'($urandom_range(0, 127));
    endtask

    // Cycle c is the period after edge c-1; edge 0 samples start.
    task automatic run_scan(input int abort_at, input int poke_at,
                            input bit chk_hold, input logic [12:0] hold_val);
        int          busy_bad;
        int          done_cycle;
        logic [12:0] exp_box;
        busy_bad   = 0;
        done_cycle = -1;
        if (abort_at == 0) exp_q.push_back(model_box());
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge CLOCK_50);
            start = (c == poke_at);
            if (c == 1 && chk_hold) check("done_drop", {31'd0, done}, 32'd0);
            if (c == abort_at) begin
                KEY[3] = 1'b0;
                #1 check("abort_zero",
                         {busy, done, found, x_min, x_max, y_min, y_max, rd_addr}, 32'd0);
                @(negedge CLOCK_50);
                KEY[3] = 1'b1;
                return;
            end
            if (done) begin
                done_cycle = c;
                break;
            end
            if (!busy) busy_bad++;
            if (c == 40) check("rd_addr_c40", {16'd0, rd_addr}, 32'd39);
            if (c == 30 && chk_hold) check("box_hold", {19'd0, box_out()}, {19'd0, hold_val});
        end
        start = 1'b0;
        check("done_cycle", done_cycle, 32'(N + 2));
        check("busy_span", busy_bad, 32'd0);
        exp_box = (exp_q.size() > 0) ? exp_q.pop_front() : 13'h1FFF;
        check("box", {19'd0, box_out()}, {19'd0, exp_box});
        @(negedge CLOCK_50);
        check("done_stable", {29'd0, done, busy, found}, {29'd0, 1'b1, 1'b0, exp_box[12]});
        check("rd_addr_hold", {16'd0, rd_addr}, 32'(N - 1));
    endtask

    // ---------------- sequence ----------------
    logic [12:0] prev_box;

    initial begin
        checks = 0;
        errors = 0;
        KEY    = 4'b0111;
        start  = 1'b0;
        fill(8'h00);
        repeat (3) @(negedge CLOCK_50);
        check("reset",
              {busy, done, found, x_min, x_max, y_min, y_max, rd_addr}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        KEY = 4'b1111;
        repeat (2) @(negedge CLOCK_50);

        load_square();
        run_scan(0, 0, 1'b0, '0);

        fill(8'h00);
        run_scan(0, 0, 1'b0, '0);

        fill(8'h7F);
        set_px(7, 7, 8'h80);
        run_scan(0, 0, 1'b0, '0);

        fill(8'h00);
        set_px(0, 0, 8'hFF);
        set_px(7, 0, 8'hFF);
        run_scan(0, 0, 1'b0, '0);

        load_square();
        run_scan(30, 0, 1'b0, '0);
        run_scan(0, 0, 1'b0, '0);

        run_scan(0, 20, 1'b0, '0);
        run_scan(0, N + 1, 1'b0, '0);

        prev_box = model_box();
        fill(8'h10);
        set_px(1, 4, 8'hC0);
        set_px(5, 6, 8'h90);
        run_scan(0, 0, 1'b1, prev_box);

        for (int r = 0; r < 2; r++) begin
            load_random();
            run_scan(0, 0, 1'b0, '0);
        end

        check("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bbox_scan.md
Name: bbox_scan

Overview:
- Upstream neighbour of the cropping stage.
- Raster-scans the source image memory (the same memory the cropper reads) and finds the bounding box of foreground pixels.
- Foreground means pixel value >= THRESH.
- Presents the box and a done flag, which the crop controller consumes to set its copy window.

Parameters:
- WIDTH, 256, image width in pixels
- HEIGHT, 256, image height in pixels
- PIX_W, 8, pixel width in bits
- THRESH, 128, foreground threshold (unsigned compare, pixel >= THRESH is foreground)
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- X_W / Y_W, derived, $clog2(WIDTH) / $clog2(HEIGHT)

Ports:
- CLOCK_50  input  1  system clock, all state on rising edge
- KEY  input  4  KEY[3] is the asynchronous active-low reset; KEY[2:0] are unused
- start  input  1  single-cycle or level request to begin a scan
- rd_addr  output  ADDR_W  read address to the image memory, equal to y*WIDTH + x
- rd_data  input  PIX_W  memory data, valid exactly 1 cycle after rd_addr (synchronous read)
- busy  output  1  high in SCAN and DRAIN
- done  output  1  scan complete; results valid
- found  output  1  at least one foreground pixel was seen
- x_min, x_max  output  X_W  box columns, inclusive
- y_min, y_max  output  Y_W  box rows, inclusive

Behaviour:
- Reset (KEY[3]=0, asynchronous): state goes to IDLE; rd_addr, busy, done, found and all box outputs go to 0. A reset during a scan aborts it with no partial result. Release is sampled on the next clock edge.
- State machine: IDLE -> SCAN -> DRAIN -> DONE.
  - IDLE or DONE, start=1: go to SCAN. Clear done and the running registers (run_xmin=WIDTH-1, run_ymin=HEIGHT-1, run_xmax=0, run_ymax=0, run_found=0). Set rd_addr=0.
  - SCAN: issue one address per cycle in raster order (x increments; when x=WIDTH-1, x wraps to 0 and y increments). After issuing address WIDTH*HEIGHT-1, go to DRAIN.
  - DRAIN: consume the last pixel for one cycle, then go to DONE.
  - DONE: done=1 and the outputs are held until the next accepted start.
- start is ignored while busy=1.
- Read pipeline: a 1-cycle valid bit plus delayed (x,y) registers accompany each address. On each valid pixel with rd_data >= THRESH:
  - run_found <= 1
  - run_xmin <= min(run_xmin, x); run_xmax <= max(run_xmax, x)
  - run_ymin <= min(run_ymin, y); run_ymax <= max(run_ymax, y)
  - All compares are unsigned.
- Timing (cycle 0 = edge where start is sampled):
  - rd_addr=k during cycle k+1
  - last data arrives in cycle N+1, where N=WIDTH*HEIGHT
  - done=1 and outputs valid from cycle N+2; total latency N+2 cycles
- Output registers load from the running registers in the same edge that enters DONE. They do not change during a scan, so the previous result stays visible until DONE is re-entered.
- Empty image: found=0 and x_min=x_max=y_min=y_max=0.
- rd_addr holds its last value in DRAIN, DONE and IDLE.
- A start in the same cycle as the DONE entry is ignored; start is only accepted in IDLE or DONE.

Test Plan (WIDTH=HEIGHT=8, THRESH=128, so N=64):
- Square of 0xFF at rows 2..5, cols 3..6, background 0x00; pulse start -> done rises in cycle 66; found=1, x_min=3, x_max=6, y_min=2, y_max=5; busy high in cycles 1..65.
- All pixels 0x00 -> done in cycle 66; found=0; all box outputs 0.
- Single 0x80 pixel at (x=7,y=7), all others 0x7F -> found=1, box (7,7)-(7,7). This checks the threshold boundary and the last-pixel drain.
- Single pixel 0xFF at (0,0) and another at (7,0) -> x_min=0, x_max=7, y_min=0, y_max=0.
- Drive KEY[3]=0 at cycle 30 of a scan, release, start again on the square image -> outputs are 0 immediately on reset; the second scan gives the correct box at cycle 66 after its start.
- Pulse start again during SCAN -> ignored, and done timing is unchanged. Restart from DONE with a new image -> done drops the cycle SCAN begins, old box is held until the new done, then the new box appears.
